// File: rtl/bist_counter_shift.sv
// BIST helper: two independent free-running counters with terminal-count
// flags, plus a two-stage start history register for edge detection.
module bist_counter_shift #(
    parameter int M_WIDTH = 4,
    parameter int N_WIDTH = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               enable_count_M,
    input  logic               enable_count_N,
    output logic [M_WIDTH-1:0] count_M,
    output logic               carry_out_M,
    output logic [N_WIDTH-1:0] count_N,
    output logic               carry_out_N,
    output logic [1:0]         start_val
);

    logic [M_WIDTH-1:0] cnt_m_q, cnt_m_d;
    logic [N_WIDTH-1:0] cnt_n_q, cnt_n_d;
    logic [1:0]         sv_q, sv_d;

    always_comb begin
        cnt_m_d = cnt_m_q;
        cnt_n_d = cnt_n_q;
        if (enable_count_M)
            cnt_m_d = cnt_m_q + 1'b1;
        if (enable_count_N)
            cnt_n_d = cnt_n_q + 1'b1;
        sv_d = {sv_q[0], start};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_m_q <= '0;
            cnt_n_q <= '0;
            sv_q    <= 2'b00;
        end else begin
            cnt_m_q <= cnt_m_d;
            cnt_n_q <= cnt_n_d;
            sv_q    <= sv_d;
        end
    end

    // Carries flag the cycle before the wrap and track the enables live.
    assign carry_out_M = (cnt_m_q == '1) && enable_count_M;
    assign carry_out_N = (cnt_n_q == '1) && enable_count_N;

    assign count_M   = cnt_m_q;
    assign count_N   = cnt_n_q;
    assign start_val = sv_q;

endmodule

// File: tb/tb_bist_counter_shift.sv
// Directed bench for bist_counter_shift: vector tables plus hand-written
// sequences for wrap, carry, start history and asynchronous reset.
`timescale 1ns/1ps
module tb_bist_counter_shift;

    logic       clk;
    logic       reset;
    logic       start;
    logic       en_m;
    logic       en_n;
    logic [3:0] count_M;
    logic       carry_out_M;
    logic [2:0] count_N;
    logic       carry_out_N;
    logic [1:0] start_val;

    int checks;
    int failures;

    typedef struct {
        logic s;
        logic em;
        logic en;
        int   m;
        int   n;
        int   sv;
        logic cm;
        logic cn;
    } vec_t;

    vec_t start_tbl[5];
    vec_t tog_tbl[8];

    bist_counter_shift #(
        .M_WIDTH(4),
        .N_WIDTH(3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .enable_count_M (en_m),
        .enable_count_N (en_n),
        .count_M        (count_M),
        .carry_out_M    (carry_out_M),
        .count_N        (count_N),
        .carry_out_N    (carry_out_N),
        .start_val      (start_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int m, input int n,
                           input int sv, input int cm, input int cn);
        chk({tag, ".count_M"}, int'(count_M), m);
        chk({tag, ".count_N"}, int'(count_N), n);
        chk({tag, ".start_val"}, int'(start_val), sv);
        chk({tag, ".carry_M"}, int'(carry_out_M), cm);
        chk({tag, ".carry_N"}, int'(carry_out_N), cn);
    endtask

    // Drive inputs between edges, then sample 1 ns after the rising edge.
    task automatic step(input logic s, input logic em, input logic en);
        start = s;
        en_m  = em;
        en_n  = en;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic s, input logic em, input logic en,
                                input int m, input int n, input int sv,
                                input logic cm, input logic cn);
        vec_t v;
        v.s = s; v.em = em; v.en = en;
        v.m = m; v.n = n; v.sv = sv;
        v.cm = cm; v.cn = cn;
        return v;
    endfunction

    initial begin
        int em_exp;
        int en_exp;

        checks   = 0;
        failures = 0;

        start_tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        start_tbl[1] = mk(1, 0, 0, 0, 0, 1, 0, 0);
        start_tbl[2] = mk(1, 0, 0, 0, 0, 3, 0, 0);
        start_tbl[3] = mk(0, 0, 0, 0, 0, 2, 0, 0);
        start_tbl[4] = mk(1, 0, 0, 0, 0, 1, 0, 0);

        tog_tbl[0] = mk(0, 1, 1, 2, 2, 0, 0, 0);
        tog_tbl[1] = mk(0, 1, 1, 3, 3, 0, 0, 0);
        tog_tbl[2] = mk(0, 1, 1, 4, 4, 0, 0, 0);
        tog_tbl[3] = mk(0, 1, 1, 5, 5, 0, 0, 0);
        tog_tbl[4] = mk(0, 1, 1, 6, 6, 0, 0, 0);
        tog_tbl[5] = mk(0, 0, 1, 6, 7, 0, 0, 1);
        tog_tbl[6] = mk(0, 0, 1, 6, 0, 0, 0, 0);
        tog_tbl[7] = mk(0, 1, 1, 7, 1, 0, 0, 0);

        reset = 1'b1;
        start = 1'b1;
        en_m  = 1'b1;
        en_n  = 1'b1;
        #1;
        chk_all("rst0", 0, 0, 0, 0, 0);

        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1);
            chk_all("rst_hold", 0, 0, 0, 0, 0);
        end

        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0);
            em_exp = (i + 1) % 16;
            chk_all("cntM", em_exp, 0, 0, (em_exp == 15) ? 1 : 0, 0);
        end

        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1);
            en_exp = i + 1;
            chk_all("cntN", 0, en_exp, 0, 0, (en_exp == 7) ? 1 : 0);
        end
        en_n = 1'b0;
        #1;
        chk("carryN_drop", int'(carry_out_N), 0);
        en_n = 1'b1;
        #1;
        chk("carryN_back", int'(carry_out_N), 1);
        step(0, 0, 1);
        chk_all("cntN_wrap", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            chk_all("cntN_hold", 0, 0, 0, 0, 0);
        end

        foreach (start_tbl[i]) begin
            step(start_tbl[i].s, start_tbl[i].em, start_tbl[i].en);
            chk_all($sformatf("start[%0d]", i), start_tbl[i].m, start_tbl[i].n,
                    start_tbl[i].sv, int'(start_tbl[i].cm), int'(start_tbl[i].cn));
        end

        for (int i = 0; i < 9; i++)
            step(0, 1, (i < 5) ? 1'b1 : 1'b0);
        chk("mid.count_M", int'(count_M), 9);
        chk("mid.count_N", int'(count_N), 5);

        #1 reset = 1'b1;
        #0.5;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        #0.5 reset = 1'b0;
        step(0, 1, 1);
        chk_all("post_rst", 1, 1, 0, 0, 0);

        foreach (tog_tbl[i]) begin
            step(tog_tbl[i].s, tog_tbl[i].em, tog_tbl[i].en);
            chk_all($sformatf("tog[%0d]", i), tog_tbl[i].m, tog_tbl[i].n,
                    tog_tbl[i].sv, int'(tog_tbl[i].cm), int'(tog_tbl[i].cn));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bist_counter_shift.md
BIST_COUNTER_SHIFT -- requirements
Module: bist_counter_shift

Interface
REQ-001 Parameter M_WIDTH, default 4: width of count_M; counter M modulus is 2^M_WIDTH.
REQ-002 Parameter N_WIDTH, default 3: width of count_N; counter N modulus is 2^N_WIDTH.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  raw start request, sampled by the shift register.
REQ-006 enable_count_M  input  1  count enable for counter M.
REQ-007 enable_count_N  input  1  count enable for counter N.
REQ-008 count_M  output  M_WIDTH  counter M value (registered).
REQ-009 carry_out_M  output  1  counter M terminal-count flag (combinational).
REQ-010 count_N  output  N_WIDTH  counter N value (registered).
REQ-011 carry_out_N  output  1  counter N terminal-count flag (combinational).
REQ-012 start_val  output  2  start history: bit0 = start sampled at the last edge, bit1 = start sampled one edge earlier.

Function
REQ-013 Counter M SHALL increment by 1 on each rising clk edge where enable_count_M=1 and reset=0, and SHALL hold otherwise.
REQ-014 Counter M SHALL wrap from 2^M_WIDTH-1 (15 by default) to 0 with no extra cycle and no saturation.
REQ-015 carry_out_M SHALL be 1 exactly when count_M = all-ones AND enable_count_M=1, else 0, so it is high in the cycle preceding the wrap.
REQ-016 Counter N SHALL increment by 1 on each rising clk edge where enable_count_N=1 and reset=0, hold otherwise, and wrap from 2^N_WIDTH-1 (7 by default) to 0.
REQ-017 carry_out_N SHALL be 1 exactly when count_N = all-ones AND enable_count_N=1, else 0.
REQ-018 The counters SHALL be fully independent; simultaneous enables SHALL update both in the same edge, and neither carry SHALL affect the other counter.
REQ-019 The shift register SHALL update on every rising clk edge (no enable): start_val <= {start_val[0], start}.
REQ-020 start_val = 2'b01 SHALL denote a start rising edge, and 2'b10 a falling edge; the block SHALL not filter or debounce glitches shorter than one clock period.
REQ-021 start and enables changing between edges SHALL have no effect until the next rising edge; the carry outputs SHALL follow enable changes combinationally.
REQ-022 No output SHALL depend on any other module; the block contains only the two counters and the shift register.

Reset
REQ-023 While reset=1, count_M=0, count_N=0 and start_val=2'b00, asynchronously and regardless of clk, start and the enables.
REQ-024 While reset=1, carry_out_M=0 and carry_out_N=0 (counts are zero, which is never all-ones).
REQ-025 Reset asserted mid-count SHALL clear state immediately; after deassertion, the first rising edge with enable=1 SHALL produce count 1.
REQ-026 Reset deassertion between edges SHALL take effect only on the next rising edge; no update SHALL occur on the edge at which reset is still high.

Verification
REQ-027 reset=1 with start=1 and both enables high for 3 edges -> counts stay 0, start_val stays 00, both carries 0.
REQ-028 Release reset, enable_count_M=1 for 16 edges -> count_M goes 1..15 then 0; carry_out_M=1 only while count_M=15.
REQ-029 enable_count_N=1 for 8 edges, then 0 for 3 edges -> count_N goes 1..7, 0, then holds 0; carry_out_N=1 only while count_N=7; carry_out_N drops when the enable drops while count_N=7.
REQ-030 start sequence 0,1,1,0,1 sampled on successive edges -> start_val 00,01,11,10,01.
REQ-031 Assert reset for 1 ns mid-count (count_M=9, count_N=5) -> both counts 0 immediately; next enabled edge gives 1.
REQ-032 Toggle enable_count_M off for 2 edges at count_M=6 -> count_M holds 6, then resumes at 7; count_N unaffected throughout.
